// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters for the IF stage.
// Lookup is combinational from the entry flops, and training comes from branch
// resolution in ID. Defining BRANCH_PREDICTOR_STATS_EN adds the lookup, hit,
// update and mispredict statistics counters and their output ports.
module branch_predictor #(
    parameter int ENTRIES    = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pcIF,
    output logic                  predictTakenIF,
    output logic [ADDR_WIDTH-1:0] predictPcIF,
    input  logic                  updateValidID,
    input  logic [ADDR_WIDTH-1:0] updatePcID,
    input  logic                  updateTakenID,
    input  logic [ADDR_WIDTH-1:0] updateTargetID,
    input  logic                  updatePredTakenID,
    input  logic                  clear
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]           lookupCount,
    output logic [31:0]           hitCount,
    output logic [31:0]           updateCount,
    output logic [31:0]           mispredictCount
`endif
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_W    = ADDR_WIDTH - IDX_BITS - 2;

    // Saturating step toward strong-taken; never wraps past 11.
    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    // Saturating step toward strong-not-taken; never wraps below 00.
    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic                  r_valid  [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];

    logic [IDX_BITS-1:0]   w_lk_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic                  w_hit;
    logic [IDX_BITS-1:0]   w_up_idx;
    logic [TAG_W-1:0]      w_up_tag;
    logic                  w_up_hit;
    logic                  w_up_write;
    logic                  w_mispredict;
    logic                  w_unused_bits;

    // Byte offset within the word never takes part in indexing or tagging.
    assign w_unused_bits = ^{pcIF[1:0], updatePcID[1:0], updatePredTakenID};

    assign w_lk_idx = pcIF[IDX_BITS+1:2];
    assign w_lk_tag = pcIF[ADDR_WIDTH-1:IDX_BITS+2];
    assign w_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign predictTakenIF = w_hit && r_ctr[w_lk_idx][1];
    assign predictPcIF    = predictTakenIF ? r_target[w_lk_idx]
                                           : pcIF + ADDR_WIDTH'(4);

    assign w_up_idx     = updatePcID[IDX_BITS+1:2];
    assign w_up_tag     = updatePcID[ADDR_WIDTH-1:IDX_BITS+2];
    assign w_up_hit     = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    // Every taken update rewrites tag and target: a hit keeps the same tag, a miss allocates.
    assign w_up_write   = !reset && !clear && updateValidID && updateTakenID;
    assign w_mispredict = updateValidID && (updatePredTakenID != updateTakenID);

    // Valid bits and direction counters: reset/clear invalidate, updates train or allocate.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (updateValidID) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= updateTakenID ? ctr_inc(r_ctr[w_up_idx])
                                                 : ctr_dec(r_ctr[w_up_idx]);
            end else if (updateTakenID) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target storage; contents are only meaningful while the entry is valid.
    always_ff @(posedge clk) begin
        if (w_up_write) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= updateTargetID;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] r_lookup_cnt;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_update_cnt;
    logic [31:0] r_mispredict_cnt;

    // Free-running statistics; only reset zeroes them, clear leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lookup_cnt     <= '0;
            r_hit_cnt        <= '0;
            r_update_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_lookup_cnt <= r_lookup_cnt + 32'd1;
            if (w_hit)         r_hit_cnt        <= r_hit_cnt + 32'd1;
            if (updateValidID) r_update_cnt     <= r_update_cnt + 32'd1;
            if (w_mispredict)  r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

    assign lookupCount     = r_lookup_cnt;
    assign hitCount        = r_hit_cnt;
    assign updateCount     = r_update_cnt;
    assign mispredictCount = r_mispredict_cnt;
`else
    logic w_unused_mispredict;
    assign w_unused_mispredict = w_mispredict;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES=64, ADDR_WIDTH=32).
// Statistics checks are compiled in when BRANCH_PREDICTOR_STATS_EN is defined.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcIF;
    logic        predictTakenIF;
    logic [31:0] predictPcIF;
    logic        updateValidID;
    logic [31:0] updatePcID;
    logic        updateTakenID;
    logic [31:0] updateTargetID;
    logic        updatePredTakenID;
    logic        clear;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] lookupCount;
    logic [31:0] hitCount;
    logic [31:0] updateCount;
    logic [31:0] mispredictCount;
`endif

    int vectors = 0;
    int errors  = 0;

    branch_predictor #(
        .ENTRIES    (64),
        .ADDR_WIDTH (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pcIF              (pcIF),
        .predictTakenIF    (predictTakenIF),
        .predictPcIF       (predictPcIF),
        .updateValidID     (updateValidID),
        .updatePcID        (updatePcID),
        .updateTakenID     (updateTakenID),
        .updateTargetID    (updateTargetID),
        .updatePredTakenID (updatePredTakenID),
        .clear             (clear)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .lookupCount       (lookupCount),
        .hitCount          (hitCount),
        .updateCount       (updateCount),
        .mispredictCount   (mispredictCount)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle branch resolution pulse; called and returns just after a falling edge.
    task automatic do_update(input logic [31:0] pc, input logic taken,
                             input logic [31:0] tgt, input logic pred);
        updateValidID     = 1'b1;
        updatePcID        = pc;
        updateTakenID     = taken;
        updateTargetID    = tgt;
        updatePredTakenID = pred;
        @(posedge clk);
        @(negedge clk);
        updateValidID     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pcIF  = 32'h0040_0010;
        #1;
        vectors++;
        if (predictTakenIF !== 1'b0) begin
            errors++;
            $display("FAIL reset_taken: got %b want 0", predictTakenIF);
        end
        vectors++;
        if (predictPcIF !== 32'h0040_0014) begin
            errors++;
            $display("FAIL reset_pc: got %h want 00400014", predictPcIF);
        end
`ifdef BRANCH_PREDICTOR_STATS_EN
        vectors++;
        if ({lookupCount, hitCount, updateCount, mispredictCount} !== 128'd0) begin
            errors++;
            $display("FAIL reset_stats: got %h %h %h %h want all 0",
                     lookupCount, hitCount, updateCount, mispredictCount);
        end
`endif
    endtask

    task automatic test_allocate();
        do_update(32'h0040_0010, 1'b1, 32'h0040_0000, 1'b0);
        pcIF = 32'h0040_0010;
        #1;
        vectors++;
        if (predictTakenIF !== 1'b1) begin
            errors++;
            $display("FAIL alloc_taken: got %b want 1", predictTakenIF);
        end
        vectors++;
        if (predictPcIF !== 32'h0040_0000) begin
            errors++;
            $display("FAIL alloc_pc: got %h want 00400000", predictPcIF);
        end
    endtask

    task automatic test_hysteresis();
        logic [3:0] taken_seq;
        logic [3:0] want_pred;
        // Allocation leaves ctr=10.
        do_update(32'h0040_0020, 1'b1, 32'h0040_1000, 1'b0);
        // NT -> 01 (not taken), T -> 10, T -> 11, T -> 11 (saturated), all predicted after each.
        taken_seq = 4'b1110;
        want_pred = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            do_update(32'h0040_0020, taken_seq[k], 32'h0040_2000, 1'b0);
            pcIF = 32'h0040_0020;
            #1;
            vectors++;
            if (predictTakenIF !== want_pred[k]) begin
                errors++;
                $display("FAIL hyst_step%0d: got %b want %b", k, predictTakenIF, want_pred[k]);
            end
        end
        // From 11 a single not-taken still predicts taken; taken updates refreshed the target.
        do_update(32'h0040_0020, 1'b0, 32'h0040_3000, 1'b1);
        pcIF = 32'h0040_0023;
        #1;
        vectors++;
        if (predictTakenIF !== 1'b1) begin
            errors++;
            $display("FAIL hyst_strong: got %b want 1", predictTakenIF);
        end
        vectors++;
        if (predictPcIF !== 32'h0040_2000) begin
            errors++;
            $display("FAIL hyst_target: got %h want 00402000", predictPcIF);
        end
        // A second not-taken drops 10 -> 01.
        do_update(32'h0040_0020, 1'b0, 32'h0040_3000, 1'b1);
        pcIF = 32'h0040_0020;
        #1;
        vectors++;
        if (predictPcIF !== 32'h0040_0024) begin
            errors++;
            $display("FAIL hyst_weak_nt: got %h want 00400024", predictPcIF);
        end
    endtask

    task automatic test_aliasing();
        do_update(32'h0000_0010, 1'b1, 32'h0000_0800, 1'b0);
        pcIF = 32'h0000_0010;
        #1;
        vectors++;
        if (predictPcIF !== 32'h0000_0800) begin
            errors++;
            $display("FAIL alias_first: got %h want 00000800", predictPcIF);
        end
        do_update(32'h0000_0110, 1'b1, 32'h0000_0900, 1'b0);
        pcIF = 32'h0000_0110;
        #1;
        vectors++;
        if (predictPcIF !== 32'h0000_0900) begin
            errors++;
            $display("FAIL alias_second: got %h want 00000900", predictPcIF);
        end
        pcIF = 32'h0000_0010;
        #1;
        vectors++;
        if ({predictTakenIF, predictPcIF} !== {1'b0, 32'h0000_0014}) begin
            errors++;
            $display("FAIL alias_evicted: got %b %h want 0 00000014", predictTakenIF, predictPcIF);
        end
    endtask

    task automatic test_same_cycle();
        // Lookup while the allocating update is in flight must see the old (empty) entry.
        pcIF              = 32'h0040_0030;
        updateValidID     = 1'b1;
        updatePcID        = 32'h0040_0030;
        updateTakenID     = 1'b1;
        updateTargetID    = 32'h0040_0300;
        updatePredTakenID = 1'b0;
        #1;
        vectors++;
        if (predictPcIF !== 32'h0040_0034) begin
            errors++;
            $display("FAIL same_cycle_old: got %h want 00400034", predictPcIF);
        end
        @(posedge clk);
        @(negedge clk);
        updateValidID = 1'b0;
        #1;
        vectors++;
        if (predictPcIF !== 32'h0040_0300) begin
            errors++;
            $display("FAIL same_cycle_new: got %h want 00400300", predictPcIF);
        end
    endtask

    task automatic test_miss_not_taken();
        do_update(32'h0040_0040, 1'b0, 32'h0040_0400, 1'b1);
        pcIF = 32'h0040_0040;
        #1;
        vectors++;
        if ({predictTakenIF, predictPcIF} !== {1'b0, 32'h0040_0044}) begin
            errors++;
            $display("FAIL miss_nt: got %b %h want 0 00400044", predictTakenIF, predictPcIF);
        end
    endtask

    task automatic test_wrap();
        pcIF = 32'hFFFF_FFFC;
        #1;
        vectors++;
        if ({predictTakenIF, predictPcIF} !== {1'b0, 32'h0000_0000}) begin
            errors++;
            $display("FAIL pc_wrap: got %b %h want 0 00000000", predictTakenIF, predictPcIF);
        end
    endtask

    task automatic test_clear_priority();
        logic [31:0] pcs [4];
        pcs[0] = 32'h0040_0050;
        pcs[1] = 32'h0040_0010;
        pcs[2] = 32'h0000_0110;
        pcs[3] = 32'h0040_0030;
        clear = 1'b1;
        do_update(32'h0040_0050, 1'b1, 32'h0040_0500, 1'b0);
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pcIF = pcs[k];
            #1;
            vectors++;
            if ({predictTakenIF, predictPcIF} !== {1'b0, pcs[k] + 32'd4}) begin
                errors++;
                $display("FAIL clear_miss%0d: got %b %h want 0 %h",
                         k, predictTakenIF, predictPcIF, pcs[k] + 32'd4);
            end
        end
        // Entries are usable again after clear.
        do_update(32'h0040_0050, 1'b1, 32'h0040_0500, 1'b0);
        pcIF = 32'h0040_0050;
        #1;
        vectors++;
        if (predictPcIF !== 32'h0040_0500) begin
            errors++;
            $display("FAIL clear_realloc: got %h want 00400500", predictPcIF);
        end
    endtask

`ifdef BRANCH_PREDICTOR_STATS_EN
    task automatic test_stats();
        pcIF  = 32'h0040_0070;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({lookupCount, hitCount, updateCount, mispredictCount} !== 128'd0) begin
            errors++;
            $display("FAIL stats_reset0: got %h %h %h %h want all 0",
                     lookupCount, hitCount, updateCount, mispredictCount);
        end
        // (pred,taken) = (1,1) (0,1) (1,0) (0,0); pcIF never hits during these.
        do_update(32'h0040_0080, 1'b1, 32'h0040_0800, 1'b1);
        do_update(32'h0040_0090, 1'b1, 32'h0040_0900, 1'b0);
        do_update(32'h0040_00A0, 1'b0, 32'h0040_0A00, 1'b1);
        do_update(32'h0040_00B0, 1'b0, 32'h0040_0B00, 1'b0);
        #1;
        vectors++;
        if ({lookupCount, hitCount, updateCount, mispredictCount} !== {32'd4, 32'd0, 32'd4, 32'd2}) begin
            errors++;
            $display("FAIL stats_updates: got %0d %0d %0d %0d want 4 0 4 2",
                     lookupCount, hitCount, updateCount, mispredictCount);
        end
        // One cycle looking up an allocated entry counts one hit.
        pcIF = 32'h0040_0080;
        @(posedge clk);
        @(negedge clk);
        pcIF  = 32'h0040_0070;
        // Clear leaves the statistics running.
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        #1;
        vectors++;
        if ({lookupCount, hitCount, updateCount, mispredictCount} !== {32'd6, 32'd1, 32'd4, 32'd2}) begin
            errors++;
            $display("FAIL stats_clear: got %0d %0d %0d %0d want 6 1 4 2",
                     lookupCount, hitCount, updateCount, mispredictCount);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({lookupCount, hitCount, updateCount, mispredictCount} !== 128'd0) begin
            errors++;
            $display("FAIL stats_reset1: got %0d %0d %0d %0d want all 0",
                     lookupCount, hitCount, updateCount, mispredictCount);
        end
    endtask
`endif

    initial begin
        reset             = 1'b1;
        clear             = 1'b0;
        pcIF              = '0;
        updateValidID     = 1'b0;
        updatePcID        = '0;
        updateTakenID     = 1'b0;
        updateTargetID    = '0;
        updatePredTakenID = 1'b0;
        @(negedge clk);
        test_reset();
        test_allocate();
        test_hysteresis();
        test_aliasing();
        test_same_cycle();
        test_miss_not_taken();
        test_wrap();
        test_clear_priority();
`ifdef BRANCH_PREDICTOR_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
